// File: rtl/reg_bank_loader_pkg.sv
// Shared constants, control-bit positions and FSM encoding
// for the staged register bank loader.
package reg_bank_pkg;

  localparam int NUM_REGS    = 32;
  localparam int DATA_W      = 4;
  localparam int ADDR_W      = 5;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;

  localparam logic [ADDR_W-1:0] COMMIT_ADDR = 5'd31;

  localparam int CLR_BIT = 1;
  localparam int NOW_BIT = 0;
  localparam int ARM_BIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT
  } state_t;

endpackage

// File: rtl/reg_bank_loader_if.sv
// Nibble-write bus from the UART decoder.
// The UART drives it; the loader consumes it.
interface reg_bank_loader_if;
  import reg_bank_pkg::*;

  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_data;
  logic              uart_ready;

  modport master (
    output uart_addr,
    output uart_data,
    output uart_ready
  );

  modport slave (
    input uart_addr,
    input uart_data,
    input uart_ready
  );

endinterface

// File: rtl/reg_bank_loader_sync_rise.sv
// N-flop synchronizer followed by a registered
// rising-edge pulse for an asynchronous level.
module sync_rise #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [N-1:0] sync_q;
  logic [N-1:0] fill_q;
  logic         prev_q;

  // fill_q marks when the chain holds real samples; until then
  // prev_q is held high so a level already high at reset release
  // is never mistaken for a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
      rise   <= 1'b0;
    end else begin
      sync_q[0] <= d;
      fill_q[0] <= 1'b1;
      for (int i = 1; i < N; i++) begin
        sync_q[i] <= sync_q[i-1];
        fill_q[i] <= fill_q[i-1];
      end
      prev_q <= fill_q[N-1] ? sync_q[N-1] : 1'b1;
      rise   <= fill_q[N-1] & sync_q[N-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/reg_bank_loader.sv
// Staging bank fed by UART nibble writes, committed
// atomically into the active bank now or on frame_tick.
module reg_bank_loader #(
  parameter int NUM_REGS    = reg_bank_pkg::NUM_REGS,
  parameter int DATA_W      = reg_bank_pkg::DATA_W,
  parameter int SYNC_STAGES = reg_bank_pkg::SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  reg_bank_loader_if.slave           uart,
  input  logic                       frame_tick,
  output logic [NUM_REGS*DATA_W-1:0] active_regs,
  output logic                       write_strobe,
  output logic                       commit_pending,
  output logic                       commit_done,
  output logic [7:0]                 write_count
);
  import reg_bank_pkg::*;

  logic              accept;
  logic              is_ctrl;
  logic              now_q;
  logic              arm_q;
  logic              load;
  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] stage_q  [NUM_REGS-1];
  logic [DATA_W-1:0] active_q [NUM_REGS-1];

  sync_rise #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart.uart_ready),
    .rise  (accept)
  );

  assign is_ctrl = (uart.uart_addr == COMMIT_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS-1; i++)
        stage_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REGS-1; i++) begin
        unique case (1'b1)
          is_ctrl && uart.uart_data[CLR_BIT]:
            stage_q[i] <= '0;
          !is_ctrl && uart.uart_addr == ADDR_W'(i):
            stage_q[i] <= uart.uart_data;
          default: ;
        endcase
      end
    end
  end

  // Control writes are decoded into one-cycle requests so a
  // clear in the same write lands in staging before the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_strobe <= 1'b0;
      write_count  <= '0;
      now_q        <= 1'b0;
      arm_q        <= 1'b0;
    end else begin
      write_strobe <= accept;
      if (accept)
        write_count <= write_count + 8'd1;
      now_q <= accept & is_ctrl
             & uart.uart_data[NOW_BIT];
      arm_q <= accept & is_ctrl
             & ~uart.uart_data[NOW_BIT]
             & uart.uart_data[ARM_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (now_q)
          state_d = COMMIT;
        else if (arm_q)
          state_d = ARMED;
      end
      ARMED: begin
        if (now_q || frame_tick)
          state_d = COMMIT;
      end
      COMMIT: begin
        if (now_q)
          state_d = COMMIT;
        else if (arm_q)
          state_d = ARMED;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The copy happens on the edge entering COMMIT, so a staging
  // write on that same edge is not seen by the active bank.
  assign load = (state_d == COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS-1; i++)
        active_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_REGS-1; i++)
        active_q[i] <= stage_q[i];
    end
  end

  always_comb begin
    active_regs = '0;
    for (int i = 0; i < NUM_REGS-1; i++)
      active_regs[i*DATA_W +: DATA_W] = active_q[i];
  end

  assign commit_pending = (state_q == ARMED);
  assign commit_done    = (state_q == COMMIT);

endmodule

// File: tb/tb_reg_bank_loader.sv
// Randomized bench for reg_bank_loader against a
// transaction-level model of the staging/active banks.
module tb_reg_bank_loader;
  import reg_bank_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_tick = 1'b0;
  logic [127:0] active_regs;
  logic         write_strobe;
  logic         commit_pending;
  logic         commit_done;
  logic [7:0]   write_count;

  reg_bank_loader_if bus ();

  reg_bank_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart           (bus),
    .frame_tick     (frame_tick),
    .active_regs    (active_regs),
    .write_strobe   (write_strobe),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .write_count    (write_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] stg [32];
  logic [3:0] act [32];
  logic       armed;
  logic [7:0] cnt;

  int lat, nstb, ndone, done_k;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      stg[i] = '0;
      act[i] = '0;
    end
    armed = 1'b0;
    cnt   = '0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 31; i++)
      act[i] = stg[i];
    armed = 1'b0;
  endtask

  task automatic model_write(input logic [4:0] a,
                             input logic [3:0] d);
    cnt = cnt + 8'd1;
    if (a != 5'd31) begin
      stg[a] = d;
    end else begin
      if (d[1])
        for (int i = 0; i < 32; i++) stg[i] = '0;
      if (d[0]) model_commit();
      else if (d[3]) armed = 1'b1;
    end
  endtask

  function automatic logic [127:0] exp_flat();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 31; i++)
      r[4*i +: 4] = act[i];
    return r;
  endfunction

  // One UART message: ready held for `hold` cycles; frame_tick
  // optionally pulsed on cycle tick_at (edge index from ready).
  task automatic send(input logic [4:0] a,
                      input logic [3:0] d,
                      input int hold,
                      input int tick_at);
    lat = -1; nstb = 0; ndone = 0; done_k = -1;
    for (int k = 0; k < hold + 8; k++) begin
      @(negedge clk);
      bus.uart_addr  = a;
      bus.uart_data  = d;
      bus.uart_ready = (k < hold);
      frame_tick     = (k == tick_at);
      @(posedge clk);
      #1;
      if (write_strobe) begin
        nstb++;
        if (lat < 0) lat = k;
      end
      if (commit_done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a,
                          input logic [3:0] d,
                          input int hold,
                          input int tick_at);
    send(a, d, hold, tick_at);
    if (tick_at >= 0 && tick_at <= 3 && armed)
      model_commit();
    model_write(a, d);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (active_regs !== '0) begin
      miscompares++;
      $display("FAIL reset_active got %h want 0", active_regs);
    end
    vectors++;
    if (write_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_count got %0d want 0", write_count);
    end
    vectors++;
    if ({write_strobe, commit_pending, commit_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000",
               {write_strobe, commit_pending, commit_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_immediate();
    do_write(5'd3, 4'hA, 5, -1);
    vectors++;
    if (lat !== 3 || nstb !== 1) begin
      miscompares++;
      $display("FAIL imm_latency got lat=%0d n=%0d want 3/1",
               lat, nstb);
    end
    do_write(5'd31, 4'h1, 5, -1);
    vectors++;
    if (done_k !== 4 || ndone !== 1) begin
      miscompares++;
      $display("FAIL imm_done got k=%0d n=%0d want 4/1",
               done_k, ndone);
    end
    vectors++;
    if (active_regs[15:12] !== 4'hA) begin
      miscompares++;
      $display("FAIL imm_reg3 got %h want a", active_regs[15:12]);
    end
    vectors++;
    if (write_count !== 8'd2) begin
      miscompares++;
      $display("FAIL imm_count got %0d want 2", write_count);
    end
    vectors++;
    if (active_regs !== exp_flat()) begin
      miscompares++;
      $display("FAIL imm_bank got %h want %h",
               active_regs, exp_flat());
    end
  endtask

  task automatic test_frame();
    do_write(5'd5, 4'h7, 5, -1);
    do_write(5'd31, 4'h8, 5, -1);
    vectors++;
    if (commit_pending !== 1'b1 || ndone !== 0) begin
      miscompares++;
      $display("FAIL frm_armed got p=%b n=%0d want 1/0",
               commit_pending, ndone);
    end
    repeat ($urandom_range(1, 20)) @(negedge clk);
    #1;
    vectors++;
    if (commit_pending !== 1'b1 ||
        active_regs[23:20] !== act[5]) begin
      miscompares++;
      $display("FAIL frm_wait got p=%b r5=%h want 1/%h",
               commit_pending, active_regs[23:20], act[5]);
    end
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    if (armed) model_commit();
    vectors++;
    if (active_regs[23:20] !== 4'h7 ||
        commit_pending !== 1'b0 || commit_done !== 1'b1) begin
      miscompares++;
      $display("FAIL frm_tick got r5=%h p=%b d=%b want 7/0/1",
               active_regs[23:20], commit_pending, commit_done);
    end
    vectors++;
    if (active_regs !== exp_flat()) begin
      miscompares++;
      $display("FAIL frm_bank got %h want %h",
               active_regs, exp_flat());
    end
    // a tick while idle must not commit
    do_write(5'd5, 4'(7 + $urandom_range(1, 8)), 5, -1);
    send(5'd6, 4'($urandom), 5, 6);
    model_write(5'd6, bus.uart_data);
    vectors++;
    if (ndone !== 0 || active_regs !== exp_flat()) begin
      miscompares++;
      $display("FAIL frm_idle got n=%0d bank=%h want 0/%h",
               ndone, active_regs, exp_flat());
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 31; i++)
      do_write(5'(i), 4'(i), 5, -1);
    do_write(5'd31, 4'h1, 5, -1);
    vectors++;
    if (active_regs !== exp_flat()) begin
      miscompares++;
      $display("FAIL clr_load got %h want %h",
               active_regs, exp_flat());
    end
    for (int i = 0; i < 8; i++)
      do_write(5'($urandom_range(0, 30)), 4'($urandom), 5, -1);
    do_write(5'd31, 4'h3, 5, -1);
    vectors++;
    if (active_regs !== '0 || ndone !== 1) begin
      miscompares++;
      $display("FAIL clr_commit got %h n=%0d want 0/1",
               active_regs, ndone);
    end
    do_write(5'd31, 4'h1, 5, -1);
    vectors++;
    if (active_regs !== exp_flat() ||
        active_regs[127:124] !== 4'h0) begin
      miscompares++;
      $display("FAIL clr_staging got %h want %h",
               active_regs, exp_flat());
    end
  endtask

  task automatic test_tick_collision();
    logic [3:0] oldv, newv;
    oldv = 4'($urandom);
    newv = oldv ^ 4'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++)
      do_write(5'($urandom_range(3, 30)), 4'($urandom), 5, -1);
    do_write(5'd2, oldv, 5, -1);
    do_write(5'd31, 4'h1, 5, -1);
    do_write(5'd31, 4'h8, 5, -1);
    do_write(5'd2, newv, 5, 3);
    vectors++;
    if (done_k !== 3 || commit_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL col_commit got k=%0d p=%b want 3/0",
               done_k, commit_pending);
    end
    vectors++;
    if (active_regs[11:8] !== oldv ||
        active_regs !== exp_flat()) begin
      miscompares++;
      $display("FAIL col_old got %h want %h",
               active_regs, exp_flat());
    end
    do_write(5'd31, 4'h1, 5, -1);
    vectors++;
    if (active_regs[11:8] !== newv) begin
      miscompares++;
      $display("FAIL col_new got %h want %h",
               active_regs[11:8], newv);
    end
  endtask

  task automatic test_held_ready();
    do_write(5'($urandom_range(0, 30)), 4'($urandom), 20, -1);
    vectors++;
    if (nstb !== 1 || write_count !== cnt) begin
      miscompares++;
      $display("FAIL held_one got n=%0d c=%0d want 1/%0d",
               nstb, write_count, cnt);
    end
    @(negedge clk);
    bus.uart_addr  = 5'd7;
    bus.uart_data  = 4'h9;
    bus.uart_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    vectors++;
    if (active_regs !== '0 || write_count !== 8'd0 ||
        {write_strobe, commit_pending, commit_done} !== 3'b0) begin
      miscompares++;
      $display("FAIL rst_mid got %h c=%0d want all 0",
               active_regs, write_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nstb = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      bus.uart_ready = (k < 6);
      @(posedge clk);
      #1;
      if (write_strobe) nstb++;
    end
    vectors++;
    if (nstb !== 0 || write_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_lost got n=%0d c=%0d want 0/0",
               nstb, write_count);
    end
    do_write(5'd7, 4'h9, 5, -1);
    vectors++;
    if (lat !== 3 || write_count !== 8'd1) begin
      miscompares++;
      $display("FAIL rst_next got lat=%0d c=%0d want 3/1",
               lat, write_count);
    end
  endtask

  task automatic test_wrap();
    int tot_s, tot_d;
    logic [7:0] start;
    logic [4:0] a;
    logic [3:0] d;
    start = cnt;
    tot_s = 0;
    tot_d = 0;
    for (int n = 0; n < 257; n++) begin
      a = 5'($urandom_range(0, 31));
      d = (a == 5'd31) ? (($urandom & 1) ? 4'h4 : 4'h0)
                       : 4'($urandom);
      do_write(a, d, 4, -1);
      tot_s += nstb;
      tot_d += ndone;
    end
    vectors++;
    if (write_count !== 8'(start + 8'd1) || write_count !== cnt) begin
      miscompares++;
      $display("FAIL wrap_count got %0d want %0d",
               write_count, 8'(start + 8'd1));
    end
    vectors++;
    if (tot_s !== 257 || tot_d !== 0 || commit_pending !== 1'b0 ||
        active_regs !== exp_flat()) begin
      miscompares++;
      $display("FAIL wrap_side got s=%0d d=%0d p=%b want 257/0/0",
               tot_s, tot_d, commit_pending);
    end
    do_write(5'd31, 4'h1, 5, -1);
    vectors++;
    if (active_regs !== exp_flat()) begin
      miscompares++;
      $display("FAIL wrap_bank got %h want %h",
               active_regs, exp_flat());
    end
  endtask

  initial begin
    bus.uart_addr  = '0;
    bus.uart_data  = '0;
    bus.uart_ready = 1'b0;
    model_clear();
    test_reset();
    test_immediate();
    test_frame();
    test_clear();
    test_tick_collision();
    test_held_ready();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
